// File: rtl/plinko_histogram_reader.sv
// Snapshots the eight plinkoboard bin counters on start and streams them as
// {bin, count} words over valid/ready, reporting peak bin and total at the end.
module plinko_histogram_reader #(
    parameter int SKIP_EMPTY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] count1,
    input  logic [4:0] count2,
    input  logic [4:0] count3,
    input  logic [4:0] count4,
    input  logic [4:0] count5,
    input  logic [4:0] count6,
    input  logic [4:0] count7,
    input  logic [4:0] count8,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_bin,
    output logic [4:0] out_count,
    output logic       out_last,
    output logic       busy,
    output logic       done,
    output logic [2:0] peak_bin,
    output logic [4:0] peak_count,
    output logic [7:0] total
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] cur_q, cur_d;
    logic [4:0] snap_q [8];
    logic [4:0] snap_d [8];
    logic [2:0] peak_bin_q, peak_bin_d;
    logic [4:0] peak_count_q, peak_count_d;
    logic [7:0] total_q, total_d;

    logic [4:0] live [8];
    logic       first_found, next_found;
    logic [2:0] first_bin, next_bin;
    logic [2:0] scan_bin;
    logic [4:0] scan_count;
    logic [7:0] scan_total;

    assign live[0] = count1;
    assign live[1] = count2;
    assign live[2] = count3;
    assign live[3] = count4;
    assign live[4] = count5;
    assign live[5] = count6;
    assign live[6] = count7;
    assign live[7] = count8;

    function automatic logic emit_ok(input logic [4:0] c);
        return (SKIP_EMPTY == 0) || (c != 5'd0);
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            snap_d[i] = snap_q[i];
        end
        if (state_q == ST_IDLE && start) begin
            for (int i = 0; i < 8; i++) begin
                snap_d[i] = live[i];
            end
        end
    end

    // First emit bin looks at the incoming snapshot; the next one at the held snapshot.
    always_comb begin
        first_found = 1'b0;
        first_bin   = 3'd0;
        next_found  = 1'b0;
        next_bin    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!first_found && emit_ok(snap_d[i])) begin
                first_found = 1'b1;
                first_bin   = 3'(i);
            end
            if (!next_found && (i > int'(cur_q)) && emit_ok(snap_q[i])) begin
                next_found = 1'b1;
                next_bin   = 3'(i);
            end
        end
    end

    always_comb begin
        scan_bin   = 3'd0;
        scan_count = 5'd0;
        scan_total = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (snap_d[i] > scan_count) begin
                scan_bin   = 3'(i);
                scan_count = snap_d[i];
            end
            scan_total = scan_total + {3'b000, snap_d[i]};
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        peak_bin_d   = peak_bin_q;
        peak_count_d = peak_count_q;
        total_d      = total_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (first_found) begin
                        state_d = ST_SEND;
                        cur_d   = first_bin;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (next_found) begin
                        cur_d = next_bin;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            peak_bin_d   = scan_bin;
            peak_count_d = scan_count;
            total_d      = scan_total;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_q        <= 3'd0;
            peak_bin_q   <= 3'd0;
            peak_count_q <= 5'd0;
            total_q      <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                snap_q[i] <= 5'd0;
            end
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            peak_bin_q   <= peak_bin_d;
            peak_count_q <= peak_count_d;
            total_q      <= total_d;
            for (int i = 0; i < 8; i++) begin
                snap_q[i] <= snap_d[i];
            end
        end
    end

    assign out_valid  = (state_q == ST_SEND);
    assign out_bin    = out_valid ? cur_q : 3'd0;
    assign out_count  = out_valid ? snap_q[cur_q] : 5'd0;
    assign out_last   = out_valid && !next_found;
    assign busy       = (state_q == ST_SEND) || (state_q == ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign peak_bin   = peak_bin_q;
    assign peak_count = peak_count_q;
    assign total      = total_q;

endmodule

// File: tb/tb_plinko_histogram_reader.sv
// Drives two readers (SKIP_EMPTY=0 and 1) with shared inputs and checks them each
// cycle against a transaction-level model of the readout.
module tb_plinko_histogram_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, out_ready;
    logic [4:0] cnt [8];
    logic       ov [2];
    logic       ol [2];
    logic       bsy [2];
    logic       dn [2];
    logic [2:0] ob [2];
    logic [2:0] pb [2];
    logic [4:0] oc [2];
    logic [4:0] pc [2];
    logic [7:0] tot [2];

    plinko_histogram_reader #(.SKIP_EMPTY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start),
        .count1(cnt[0]), .count2(cnt[1]), .count3(cnt[2]), .count4(cnt[3]),
        .count5(cnt[4]), .count6(cnt[5]), .count7(cnt[6]), .count8(cnt[7]),
        .out_valid(ov[0]), .out_ready(out_ready), .out_bin(ob[0]), .out_count(oc[0]),
        .out_last(ol[0]), .busy(bsy[0]), .done(dn[0]),
        .peak_bin(pb[0]), .peak_count(pc[0]), .total(tot[0])
    );

    plinko_histogram_reader #(.SKIP_EMPTY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .count1(cnt[0]), .count2(cnt[1]), .count3(cnt[2]), .count4(cnt[3]),
        .count5(cnt[4]), .count6(cnt[5]), .count7(cnt[6]), .count8(cnt[7]),
        .out_valid(ov[1]), .out_ready(out_ready), .out_bin(ob[1]), .out_count(oc[1]),
        .out_last(ol[1]), .busy(bsy[1]), .done(dn[1]),
        .peak_bin(pb[1]), .peak_count(pc[1]), .total(tot[1])
    );

    typedef struct packed {
        logic [2:0] bin;
        logic [4:0] cnt;
        logic       last;
    } word_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit en = 1'b0;

    word_t      words [2][8];
    int         wlen [2];
    int         widx [2];
    bit         streaming [2];
    bit         done_pend [2];
    logic [2:0] e_pb [2];
    logic [4:0] e_pc [2];
    logic [7:0] e_tot [2];
    logic [2:0] p_pb [2];
    logic [4:0] p_pc [2];
    logic [7:0] p_tot [2];
    int         hs_count [2];
    int         done_count [2];
    int         valid_count [2];
    int         last_done_cyc [2];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Expected word list and end-of-readout statistics from a plain copy of the counts.
    task automatic buildReadout(input int u);
        int snap [8];
        int mx, sum, pbin;
        mx = 0;
        sum = 0;
        pbin = 0;
        for (int i = 0; i < 8; i++) begin
            snap[i] = int'(cnt[i]);
            sum += snap[i];
            if (snap[i] > mx) mx = snap[i];
        end
        for (int i = 7; i >= 0; i--) begin
            if (snap[i] == mx) pbin = i;
        end
        p_pb[u]  = 3'(pbin);
        p_pc[u]  = 5'(mx);
        p_tot[u] = 8'(sum);
        wlen[u] = 0;
        for (int i = 0; i < 8; i++) begin
            if (u == 0 || snap[i] != 0) begin
                words[u][wlen[u]] = {3'(i), 5'(snap[i]), 1'b0};
                wlen[u]++;
            end
        end
        if (wlen[u] > 0) words[u][wlen[u] - 1].last = 1'b1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (en) begin
            for (int u = 0; u < 2; u++) begin : per_unit
                word_t w;
                bit    ev;
                bit    nd;
                ev = streaming[u];
                w  = ev ? words[u][widx[u]] : '0;
                if (done_pend[u]) begin
                    e_pb[u]  = p_pb[u];
                    e_pc[u]  = p_pc[u];
                    e_tot[u] = p_tot[u];
                end
                checkOutput($sformatf("u%0d out_valid", u), 32'(ov[u]), 32'(ev));
                checkOutput($sformatf("u%0d out_bin", u), 32'(ob[u]), 32'(w.bin));
                checkOutput($sformatf("u%0d out_count", u), 32'(oc[u]), 32'(w.cnt));
                checkOutput($sformatf("u%0d out_last", u), 32'(ol[u]), 32'(w.last));
                checkOutput($sformatf("u%0d done", u), 32'(dn[u]), 32'(done_pend[u]));
                checkOutput($sformatf("u%0d busy", u), 32'(bsy[u]), 32'(ev || done_pend[u]));
                checkOutput($sformatf("u%0d peak_bin", u), 32'(pb[u]), 32'(e_pb[u]));
                checkOutput($sformatf("u%0d peak_count", u), 32'(pc[u]), 32'(e_pc[u]));
                checkOutput($sformatf("u%0d total", u), 32'(tot[u]), 32'(e_tot[u]));
                if (ov[u] === 1'b1) valid_count[u]++;
                if (ov[u] === 1'b1 && out_ready) hs_count[u]++;
                if (dn[u] === 1'b1) begin
                    done_count[u]++;
                    last_done_cyc[u] = cyc;
                end
                nd = 1'b0;
                if (rst) begin
                    streaming[u] = 1'b0;
                    e_pb[u]  = '0;
                    e_pc[u]  = '0;
                    e_tot[u] = '0;
                end else if (streaming[u]) begin
                    if (out_ready) begin
                        widx[u]++;
                        if (w.last) begin
                            streaming[u] = 1'b0;
                            nd = 1'b1;
                        end
                    end
                end else if (!done_pend[u] && start) begin
                    buildReadout(u);
                    if (wlen[u] == 0) begin
                        nd = 1'b1;
                    end else begin
                        streaming[u] = 1'b1;
                        widx[u] = 0;
                    end
                end
                done_pend[u] = nd;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int a0, input int a1, input int a2, input int a3,
                                 input int a4, input int a5, input int a6, input int a7);
        cnt[0] = 5'(a0); cnt[1] = 5'(a1); cnt[2] = 5'(a2); cnt[3] = 5'(a3);
        cnt[4] = 5'(a4); cnt[5] = 5'(a5); cnt[6] = 5'(a6); cnt[7] = 5'(a7);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int n;
        n = 0;
        while ((bsy[0] !== 1'b0 || bsy[1] !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, " idle within budget"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sc, hb0, hb1, vb0, vb1, db0, db1, n;
        for (int u = 0; u < 2; u++) begin
            streaming[u] = 0; done_pend[u] = 0; widx[u] = 0; wlen[u] = 0;
            e_pb[u] = '0; e_pc[u] = '0; e_tot[u] = '0;
            p_pb[u] = '0; p_pc[u] = '0; p_tot[u] = '0;
            hs_count[u] = 0; done_count[u] = 0; valid_count[u] = 0; last_done_cyc[u] = 0;
        end
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        en = 1'b1;
        tick();
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            checkOutput("reset out_valid", 32'(ov[u]), 32'd0);
            checkOutput("reset busy", 32'(bsy[u]), 32'd0);
            checkOutput("reset done", 32'(dn[u]), 32'd0);
            checkOutput("reset total", 32'(tot[u]), 32'd0);
            checkOutput("reset peak_count", 32'(pc[u]), 32'd0);
        end

        $display("[TB] basic readout");
        applyStimulus(3, 0, 7, 1, 0, 0, 2, 5);
        sc = cyc; hb0 = hs_count[0]; hb1 = hs_count[1]; vb0 = valid_count[0];
        db0 = done_count[0]; db1 = done_count[1];
        pulseStart();
        waitIdle(40, "basic");
        for (int u = 0; u < 2; u++) begin
            checkOutput("basic peak_bin", 32'(pb[u]), 32'd2);
            checkOutput("basic peak_count", 32'(pc[u]), 32'd7);
            checkOutput("basic total", 32'(tot[u]), 32'd18);
        end
        checkOutput("basic u0 words", 32'(hs_count[0] - hb0), 32'd8);
        checkOutput("basic u1 words", 32'(hs_count[1] - hb1), 32'd5);
        checkOutput("basic u0 valid cycles", 32'(valid_count[0] - vb0), 32'd8);
        checkOutput("basic u0 done count", 32'(done_count[0] - db0), 32'd1);
        checkOutput("basic u1 done count", 32'(done_count[1] - db1), 32'd1);
        checkOutput("basic u0 done cycle", 32'(last_done_cyc[0] - sc), 32'd9);
        checkOutput("basic u1 done cycle", 32'(last_done_cyc[1] - sc), 32'd6);

        $display("[TB] backpressure");
        hb0 = hs_count[0]; hb1 = hs_count[1]; vb0 = valid_count[0]; vb1 = valid_count[1];
        start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            out_ready = (k % 2 == 1);
            tick();
        end
        out_ready = 1'b1;
        waitIdle(40, "backpressure");
        checkOutput("bp u0 words", 32'(hs_count[0] - hb0), 32'd8);
        checkOutput("bp u0 valid cycles", 32'(valid_count[0] - vb0), 32'd16);
        checkOutput("bp u1 words", 32'(hs_count[1] - hb1), 32'd5);
        checkOutput("bp u1 valid cycles", 32'(valid_count[1] - vb1), 32'd10);

        $display("[TB] snapshot and start rules");
        db0 = done_count[0]; db1 = done_count[1];
        start = 1'b1;
        tick();
        cnt[0] = 5'd9;
        tick();
        start = 1'b0;
        waitIdle(40, "snapshot");
        cnt[0] = 5'd3;
        checkOutput("snap u0 done count", 32'(done_count[0] - db0), 32'd1);
        checkOutput("snap u1 done count", 32'(done_count[1] - db1), 32'd1);
        checkOutput("snap u0 total", 32'(tot[0]), 32'd18);
        checkOutput("snap u1 total", 32'(tot[1]), 32'd18);

        $display("[TB] ties");
        applyStimulus(31, 0, 0, 31, 0, 0, 0, 31);
        pulseStart();
        waitIdle(40, "ties");
        for (int u = 0; u < 2; u++) begin
            checkOutput("ties peak_bin", 32'(pb[u]), 32'd0);
            checkOutput("ties peak_count", 32'(pc[u]), 32'd31);
            checkOutput("ties total", 32'(tot[u]), 32'd93);
        end

        $display("[TB] all zero");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        sc = cyc; vb0 = valid_count[0]; vb1 = valid_count[1];
        pulseStart();
        waitIdle(40, "zero");
        checkOutput("zero u1 done cycle", 32'(last_done_cyc[1] - sc), 32'd1);
        checkOutput("zero u1 valid cycles", 32'(valid_count[1] - vb1), 32'd0);
        checkOutput("zero u0 valid cycles", 32'(valid_count[0] - vb0), 32'd8);
        for (int u = 0; u < 2; u++) begin
            checkOutput("zero total", 32'(tot[u]), 32'd0);
            checkOutput("zero peak_bin", 32'(pb[u]), 32'd0);
            checkOutput("zero peak_count", 32'(pc[u]), 32'd0);
        end

        $display("[TB] reset mid-readout");
        applyStimulus(3, 0, 7, 1, 0, 0, 2, 5);
        hb0 = hs_count[0]; db0 = done_count[0]; db1 = done_count[1];
        pulseStart();
        n = 0;
        while (hs_count[0] - hb0 < 3 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("reset wait handshakes", 32'(n < 20), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            checkOutput("after reset out_valid", 32'(ov[u]), 32'd0);
            checkOutput("after reset busy", 32'(bsy[u]), 32'd0);
            checkOutput("after reset out_count", 32'(oc[u]), 32'd0);
        end
        tick();
        tick();
        checkOutput("reset u0 no done", 32'(done_count[0] - db0), 32'd0);
        checkOutput("reset u1 no done", 32'(done_count[1] - db1), 32'd0);
        hb0 = hs_count[0];
        pulseStart();
        waitIdle(40, "replay");
        checkOutput("replay u0 words", 32'(hs_count[0] - hb0), 32'd8);
        checkOutput("replay u0 total", 32'(tot[0]), 32'd18);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                cnt[$urandom_range(0, 7)] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            end
            start     = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; out_ready = 1'b1;
        waitIdle(50, "random drain");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
